// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and frame-shape constants,
// used by both the transmit and receive paths.
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int NBITS         = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with occupancy count; storage and pointers only, shared with the
// receive path. DEPTH must be a power of two so pointers wrap naturally.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level == (AW+1)'(DEPTH));
    assign wr_en = push && !full;
    assign rd_en = pop && (level != '0);
    assign rdata = mem[rd_ptr];

    // Contents need no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)
                level <= level + (AW+1)'(1);
            else if (rd_en && !wr_en)
                level <= level - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN
// to add an even-parity bit (8E1). Tx is registered one clock behind the FSM.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int BAUD_DIV = 325
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NBITS-1:0]        TxData,
    input  logic                    TxValid,
    output logic                    TxReady,
    output logic                    Tx,
    output logic                    TxBusy,
    output logic                    TxDone,
    output logic [$clog2(DEPTH):0]  Level
);

    localparam int DW = $clog2(BAUD_DIV + 2);

    tx_state_e        state, state_next;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] rdata;
    logic [2:0]       bit_cnt;
    logic [3:0]       tick_cnt;
    logic [DW-1:0]    div_cnt;
    logic             full;
    logic             pop;
    logic             shift;
    logic             done_next;
    logic             tx_next;
    logic             tick;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par;
`endif

    uart_fifo #(.DEPTH(DEPTH), .WIDTH(NBITS)) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (TxValid),
        .wdata (TxData),
        .pop   (pop),
        .rdata (rdata),
        .level (Level),
        .full  (full)
    );

    assign TxReady = !full;
    assign TxBusy  = (state != IDLE);
    assign tick    = (div_cnt == DW'(BAUD_DIV));
    assign bit_end = tick && (tick_cnt == 4'(TICKS_PER_BIT - 1));

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shift      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: if (Level != '0) begin
                pop        = 1'b1;
                state_next = START;
            end
            START: if (bit_end) state_next = DATA;
            DATA: if (bit_end) begin
                shift = 1'b1;
                if (bit_cnt == 3'(NBITS - 1))
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_next = STOP;
`endif
            STOP: if (bit_end) begin
                done_next = 1'b1;
                // Chain straight into the next start bit when data is waiting.
                if (Level != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:  tx_next = 1'b0;
            DATA:   tx_next = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = par;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            div_cnt  <= '0;
            Tx       <= 1'b1;
            TxDone   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            Tx     <= tx_next;
            TxDone <= done_next;
            if (pop) begin
                shreg   <= rdata;
                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= ^rdata;
`endif
            end else if (shift) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (pop || state == IDLE) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                tick_cnt <= tick_cnt + 4'd1;
            end else begin
                div_cnt  <= div_cnt + DW'(1);
            end
        end
    end

endmodule
